// File: rtl/img_pipe_pkg.sv
// Shared constants for the image pipeline: luminance coefficients, pipeline depth
// and default frame geometry (also used by the bilinear scaler).
package img_pipe_pkg;

    typedef logic [7:0] pix8_t;

    localparam int unsigned COEF_R         = 77;
    localparam int unsigned COEF_G         = 150;
    localparam int unsigned COEF_B         = 29;
    localparam int unsigned Y_ROUND        = 128;
    localparam int unsigned PIPE_DEPTH     = 3;
    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;

endpackage

// File: rtl/rgb_to_y.sv
// Three-stage luminance pipeline: products, rounded sum, registered gray output.
module rgb_to_y
    import img_pipe_pkg::*;
(
    input  logic  clk_in1,
    input  logic  rst_n,
    input  logic  valid_in,
    input  pix8_t r,
    input  pix8_t g,
    input  pix8_t b,
    output logic  valid_out,
    output pix8_t y
);

    logic [14:0] prod_r;
    logic [15:0] prod_g;
    logic [12:0] prod_b;
    logic [15:0] sum;
    logic        v1;
    logic        v2;

    // Max sum is 65408, so the 16-bit accumulator never overflows.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            prod_r    <= '0;
            prod_g    <= '0;
            prod_b    <= '0;
            sum       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            valid_out <= 1'b0;
            y         <= '0;
        end else begin
            v1        <= valid_in;
            v2        <= v1;
            valid_out <= v2;
            if (valid_in) begin
                prod_r <= 15'(r) * 15'(COEF_R);
                prod_g <= 16'(g) * 16'(COEF_G);
                prod_b <= 13'(b) * 13'(COEF_B);
            end
            if (v1)
                sum <= 16'(prod_r) + prod_g + 16'(prod_b) + 16'(Y_ROUND);
            if (v2)
                y <= sum[15:8];
        end
    end

endmodule

// File: rtl/dvp_rgb888_to_gray.sv
// DVP RGB888 byte stream to gated 8-bit gray stream with frame skip and sync delay.
// Optional line checker compiled in with `define DVP_LINE_CHECK_EN.
module dvp_rgb888_to_gray
    import img_pipe_pkg::*;
#(
    parameter int unsigned C_IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int unsigned C_IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int unsigned C_SKIP_FRAMES = 10
)
(
    input  logic       clk_in1,
    input  logic       rst_n,
    input  logic       dvp_vsync,
    input  logic       dvp_href,
    input  logic [7:0] dvp_data,
    output logic       post_img_vsync,
    output logic       post_img_href,
    output logic [7:0] post_img_gray,
    output logic       frame_done,
    output logic       line_err
);

    logic [PIPE_DEPTH:0] vs_pipe;
    logic [PIPE_DEPTH:0] fd_pipe;
    logic                href_q;
    logic [1:0]          phase;
    pix8_t               r_hold;
    pix8_t               g_hold;
    pix8_t               b_q;
    logic                launch_q;
    logic [7:0]          skip_cnt;
    logic                pass;
    logic [15:0]         line_cnt;

    logic vs_rise;
    logic href_fall;
    logic launch;
    logic last_line;

    always_comb begin
        vs_rise   = dvp_vsync & ~vs_pipe[0];
        href_fall = href_q & ~dvp_href & ~vs_rise;
        launch    = dvp_href & ~vs_rise & (phase == 2'd2);
        last_line = (line_cnt == 16'(C_IMG_HEIGHT - 1));
    end

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe  <= '0;
            fd_pipe  <= '0;
            href_q   <= 1'b0;
            phase    <= '0;
            r_hold   <= '0;
            g_hold   <= '0;
            b_q      <= '0;
            launch_q <= 1'b0;
            skip_cnt <= '0;
            pass     <= 1'b0;
            line_cnt <= '0;
        end else begin
            vs_pipe  <= {vs_pipe[PIPE_DEPTH-1:0], dvp_vsync};
            fd_pipe  <= {fd_pipe[PIPE_DEPTH-1:0], href_fall & pass & last_line};
            href_q   <= dvp_href;
            launch_q <= launch & pass;

            if (!dvp_href || vs_rise)
                phase <= '0;
            else if (phase == 2'd2)
                phase <= '0;
            else
                phase <= phase + 2'd1;

            if (dvp_href && !vs_rise) begin
                if (phase == 2'd0) r_hold <= dvp_data;
                if (phase == 2'd1) g_hold <= dvp_data;
                if (phase == 2'd2) b_q    <= dvp_data;
            end

            // The gate only changes at a frame boundary, never mid-frame.
            if (vs_rise) begin
                line_cnt <= '0;
                if (skip_cnt == 8'(C_SKIP_FRAMES))
                    pass <= 1'b1;
                else
                    skip_cnt <= skip_cnt + 8'd1;
            end else if (href_fall && line_cnt != '1) begin
                line_cnt <= line_cnt + 16'd1;
            end
        end
    end

`ifdef DVP_LINE_CHECK_EN
    logic [15:0] pix_cnt;
    logic        err_q;

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            err_q   <= 1'b0;
        end else if (vs_rise) begin
            pix_cnt <= '0;
            err_q   <= 1'b0;
        end else if (href_fall) begin
            if (pix_cnt != 16'(C_IMG_WIDTH) || phase != 2'd0)
                err_q <= 1'b1;
            pix_cnt <= '0;
        end else if (launch && pix_cnt != '1) begin
            pix_cnt <= pix_cnt + 16'd1;
        end
    end

    always_comb line_err = err_q;
`else
    always_comb line_err = 1'b0;
`endif

    always_comb begin
        post_img_vsync = vs_pipe[PIPE_DEPTH];
        frame_done     = fd_pipe[PIPE_DEPTH];
    end

    rgb_to_y u_rgb_to_y (
        .clk_in1   (clk_in1),
        .rst_n     (rst_n),
        .valid_in  (launch_q),
        .r         (r_hold),
        .g         (g_hold),
        .b         (b_q),
        .valid_out (post_img_href),
        .y         (post_img_gray)
    );

endmodule

// File: tb/tb_dvp_rgb888_to_gray.sv
// Randomized self-checking bench for dvp_rgb888_to_gray against a frame-level
// reference model; honours DVP_LINE_CHECK_EN for line_err expectations.
module tb_dvp_rgb888_to_gray;

    localparam int W    = 8;
    localparam int H    = 3;
    localparam int SKIP = 2;
`ifdef DVP_LINE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk_in1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       dvp_vsync = 1'b0;
    logic       dvp_href = 1'b0;
    logic [7:0] dvp_data = '0;
    logic       post_img_vsync;
    logic       post_img_href;
    logic [7:0] post_img_gray;
    logic       frame_done;
    logic       line_err;

    dvp_rgb888_to_gray #(
        .C_IMG_WIDTH   (W),
        .C_IMG_HEIGHT  (H),
        .C_SKIP_FRAMES (SKIP)
    ) dut (
        .clk_in1        (clk_in1),
        .rst_n          (rst_n),
        .dvp_vsync      (dvp_vsync),
        .dvp_href       (dvp_href),
        .dvp_data       (dvp_data),
        .post_img_vsync (post_img_vsync),
        .post_img_href  (post_img_href),
        .post_img_gray  (post_img_gray),
        .frame_done     (frame_done),
        .line_err       (line_err)
    );

    always #5 clk_in1 = ~clk_in1;

    int nvec = 0;
    int nbad = 0;
    int k = 0;

    // Expected outputs, three edges behind the inputs that produce them.
    logic       e_vs[0:3];
    logic       e_hr[0:3];
    logic       e_fd[0:3];
    logic [7:0] e_gy[0:3];

    // Frame-level reference model state.
    int m_rises, m_bytes, m_pix, m_lines;
    int m_rgb[0:2];
    bit m_pass, m_err, m_vs_prev, m_href_prev;

    int         strobes, fdones, first_hr, b_edge;
    logic [7:0] obs_gray[$];
    logic [7:0] pat[$];

    task automatic model_reset();
        m_rises = 0; m_bytes = 0; m_pix = 0; m_lines = 0;
        m_pass = 0; m_err = 0; m_vs_prev = 0; m_href_prev = 0;
        for (int i = 0; i < 4; i++) begin
            e_vs[i] = 0; e_hr[i] = 0; e_fd[i] = 0; e_gy[i] = '0;
        end
    endtask

    task automatic clock_cycle(input logic vs, input logic hr, input logic [7:0] d);
        bit rise, fall;
        int slot;
        dvp_vsync = vs; dvp_href = hr; dvp_data = d;
        rise = vs && !m_vs_prev;
        fall = m_href_prev && !hr && !rise;
        slot = k % 4;
        e_vs[slot] = vs; e_hr[slot] = 0; e_fd[slot] = 0; e_gy[slot] = '0;
        if (rise) begin
            m_rises++;
            m_pass = (m_rises > SKIP);
            m_bytes = 0; m_pix = 0; m_lines = 0; m_err = 0;
        end else if (hr) begin
            m_rgb[m_bytes] = int'(d);
            m_bytes++;
            if (m_bytes == 3) begin
                m_bytes = 0;
                m_pix++;
                if (m_pass) begin
                    e_hr[slot] = 1;
                    e_gy[slot] = 8'((77 * m_rgb[0] + 150 * m_rgb[1] + 29 * m_rgb[2] + 128) / 256);
                end
            end
        end else begin
            if (fall) begin
                if (m_pix != W || m_bytes != 0) m_err = 1;
                m_lines++;
                if (m_lines == H && m_pass) e_fd[slot] = 1;
                m_pix = 0;
            end
            m_bytes = 0;
        end
        m_vs_prev = vs; m_href_prev = hr;

        @(posedge clk_in1);
        k++;
        @(negedge clk_in1);
        slot = k % 4;
        nvec++;
        if (post_img_vsync !== e_vs[slot]) begin
            nbad++; $display("FAIL vsync edge %0d: got %b want %b", k, post_img_vsync, e_vs[slot]);
        end
        nvec++;
        if (post_img_href !== e_hr[slot]) begin
            nbad++; $display("FAIL href edge %0d: got %b want %b", k, post_img_href, e_hr[slot]);
        end
        if (e_hr[slot]) begin
            nvec++;
            if (post_img_gray !== e_gy[slot]) begin
                nbad++; $display("FAIL gray edge %0d: got %0d want %0d", k, post_img_gray, e_gy[slot]);
            end
        end
        nvec++;
        if (frame_done !== e_fd[slot]) begin
            nbad++; $display("FAIL frame_done edge %0d: got %b want %b", k, frame_done, e_fd[slot]);
        end
        nvec++;
        if (line_err !== (CHK && m_err)) begin
            nbad++; $display("FAIL line_err edge %0d: got %b want %b", k, line_err, CHK && m_err);
        end
        if (post_img_href === 1'b1) begin
            strobes++;
            obs_gray.push_back(post_img_gray);
            if (first_hr < 0) first_hr = k;
        end
        if (frame_done === 1'b1) fdones++;
    endtask

    task automatic send_line(input int l, input int nbytes);
        logic [7:0] d;
        for (int b = 0; b < nbytes; b++) begin
            d = (l == 0 && b < pat.size()) ? pat[b] : 8'($urandom);
            if (l == 0 && b == 2) b_edge = k + 1;
            clock_cycle(1'b0, 1'b1, d);
        end
        repeat (4) clock_cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_frame(input int bad_line, input int bad_bytes);
        strobes = 0; fdones = 0; first_hr = -1;
        obs_gray.delete();
        repeat (2) clock_cycle(1'b1, 1'b0, 8'h00);
        repeat (3) clock_cycle(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < H; l++)
            send_line(l, (l == bad_line) ? bad_bytes : 3 * W);
        repeat (2) clock_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic assert_reset();
        @(negedge clk_in1);
        rst_n = 1'b0;
        dvp_vsync = 1'b0; dvp_href = 1'b0; dvp_data = '0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk_in1);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        assert_reset();
        nvec++; if (post_img_vsync !== 1'b0) begin nbad++; $display("FAIL reset vsync: got %b want 0", post_img_vsync); end
        nvec++; if (post_img_href !== 1'b0) begin nbad++; $display("FAIL reset href: got %b want 0", post_img_href); end
        nvec++; if (post_img_gray !== 8'd0) begin nbad++; $display("FAIL reset gray: got %0d want 0", post_img_gray); end
        nvec++; if (frame_done !== 1'b0) begin nbad++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        nvec++; if (line_err !== 1'b0) begin nbad++; $display("FAIL reset line_err: got %b want 0", line_err); end
        release_reset();
    endtask

    task automatic test_skip();
        for (int f = 1; f <= 4; f++) begin
            send_frame(-1, 0);
            nvec++;
            if (strobes !== ((f > SKIP) ? W * H : 0)) begin
                nbad++; $display("FAIL skip strobes frame %0d: got %0d want %0d", f, strobes, (f > SKIP) ? W * H : 0);
            end
            nvec++;
            if (fdones !== ((f > SKIP) ? 1 : 0)) begin
                nbad++; $display("FAIL skip frame_done frame %0d: got %0d want %0d", f, fdones, (f > SKIP) ? 1 : 0);
            end
        end
    endtask

    task automatic test_colors();
        logic [7:0] want[0:3];
        want[0] = 8'd255; want[1] = 8'd77; want[2] = 8'd149; want[3] = 8'd29;
        pat = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
        send_frame(-1, 0);
        pat.delete();
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (obs_gray.size() <= i || obs_gray[i] !== want[i]) begin
                nbad++; $display("FAIL color %0d: got %0d want %0d", i, (obs_gray.size() > i) ? obs_gray[i] : 8'hxx, want[i]);
            end
        end
        nvec++;
        if (first_hr - b_edge !== 3) begin
            nbad++; $display("FAIL latency: got %0d want 3", first_hr - b_edge);
        end
    endtask

    task automatic test_bad_line(input int nbytes, input int want_strobes);
        send_frame(1, nbytes);
        nvec++;
        if (strobes !== want_strobes) begin
            nbad++; $display("FAIL bad-line strobes: got %0d want %0d", strobes, want_strobes);
        end
        nvec++;
        if (line_err !== CHK) begin
            nbad++; $display("FAIL bad-line line_err: got %b want %b", line_err, CHK);
        end
        nvec++;
        if (fdones !== 1) begin
            nbad++; $display("FAIL bad-line frame_done: got %0d want 1", fdones);
        end
        clock_cycle(1'b1, 1'b0, 8'h00);
        nvec++;
        if (line_err !== 1'b0) begin
            nbad++; $display("FAIL line_err clear at vsync: got %b want 0", line_err);
        end
    endtask

    task automatic test_vsync_in_href();
        send_frame(-1, 0);
        for (int b = 0; b < 10; b++) clock_cycle(1'b0, 1'b1, 8'($urandom));
        repeat (2) clock_cycle(1'b1, 1'b1, 8'($urandom));
        for (int b = 0; b < 7; b++) clock_cycle(1'b0, 1'b1, 8'($urandom));
        clock_cycle(1'b0, 1'b0, 8'h00);
        nvec++;
        if (line_err !== CHK) begin
            nbad++; $display("FAIL vsync-in-href line_err: got %b want %b", line_err, CHK);
        end
        for (int l = 0; l < H; l++) send_line(l + 1, 3 * W);
        repeat (3) clock_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_mid_reset();
        send_frame(-1, 0);
        repeat (2) clock_cycle(1'b1, 1'b0, 8'h00);
        repeat (3) clock_cycle(1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 3 * W / 2 + 3; b++) clock_cycle(1'b0, 1'b1, 8'($urandom_range(200, 255)));
        assert_reset();
        nvec++; if (post_img_href !== 1'b0) begin nbad++; $display("FAIL mid-reset href: got %b want 0", post_img_href); end
        nvec++; if (post_img_gray !== 8'd0) begin nbad++; $display("FAIL mid-reset gray: got %0d want 0", post_img_gray); end
        nvec++; if (post_img_vsync !== 1'b0) begin nbad++; $display("FAIL mid-reset vsync: got %b want 0", post_img_vsync); end
        release_reset();
        for (int f = 1; f <= SKIP + 1; f++) begin
            send_frame(-1, 0);
            nvec++;
            if (strobes !== ((f > SKIP) ? W * H : 0)) begin
                nbad++; $display("FAIL post-reset strobes frame %0d: got %0d want %0d", f, strobes, (f > SKIP) ? W * H : 0);
            end
        end
    endtask

    initial begin
        model_reset();
        strobes = 0; fdones = 0; first_hr = -1; b_edge = 0;
        test_reset();
        test_skip();
        test_colors();
        test_bad_line(3 * W - 1, W * H - 1);
        test_bad_line(3 * W + 3, W * H + 1);
        test_vsync_in_href();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
